// File: rtl/fetch_stage.sv
// fetch_stage: instruction fetch directly upstream of decode.
// Issues word-aligned requests to instruction memory, buffers returned words
// with their PCs in a small in-order FIFO and hands them to decode over a
// valid/ready handshake. A redirect flushes the FIFO and silently drops every
// response still in flight.
// Optional build macro FETCH_PERF_EN adds the stall_cycles counter output.
module fetch_stage #(
  parameter int             N        = 32,
  parameter int             DEPTH    = 2,
  parameter logic [N-1:0]   RESET_PC = '0
) (
  input  logic          clk,
  input  logic          rst_n,
  output logic          imem_req_valid,
  input  logic          imem_req_ready,
  output logic [N-1:0]  imem_req_addr,
  input  logic          imem_rsp_valid,
  input  logic [31:0]   imem_rsp_data,
  input  logic          redirect_valid,
  input  logic [N-1:0]  redirect_pc,
  output logic [31:0]   opcode,
  output logic [N-1:0]  opcode_pc,
  output logic          opcode_valid,
  input  logic          opcode_ready
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]   stall_cycles
`endif
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;  // FIFO pointer width
  localparam int CW = $clog2(DEPTH + 1);                 // counts 0..DEPTH

  typedef enum logic {RUN, DRAIN} state_t;

  state_t         state_q, state_d;
  logic [N-1:0]   pc_q;          // next address to request
  logic [N-1:0]   rsp_pc_q;      // address of the next response that will be kept
  logic [CW-1:0]  out_q;         // requests accepted but not yet answered
  logic [CW-1:0]  discard_q;     // in-flight responses still to be dropped
  logic [CW-1:0]  count_q;       // FIFO occupancy
  logic [PW-1:0]  wr_ptr_q;
  logic [PW-1:0]  rd_ptr_q;
  logic [31:0]    mem_data [DEPTH];
  logic [N-1:0]   mem_pc   [DEPTH];

  logic           req_fire;
  logic           push;
  logic           pop;
  logic           credit_ok;
  logic [CW-1:0]  out_nxt;
  logic [N-1:0]   redirect_target;
  logic           unused_redirect_bits;

  // The low two bits of a redirect target are ignored: fetch is word aligned.
  assign redirect_target      = {redirect_pc[N-1:2], 2'b00};
  assign unused_redirect_bits = ^redirect_pc[1:0];

  assign req_fire  = imem_req_valid && imem_req_ready;
  assign pop       = opcode_valid && opcode_ready;
  // A response is kept only when nothing is left to discard and no redirect
  // is squashing it in this very cycle.
  assign push      = imem_rsp_valid && !redirect_valid && (discard_q == '0);
  // Outstanding plus buffered may never exceed DEPTH, so a push never finds
  // the FIFO full.
  assign credit_ok = (int'(out_q) + int'(count_q)) < DEPTH;
  assign out_nxt   = out_q + CW'(req_fire) - CW'(imem_rsp_valid);

  // State register for the RUN/DRAIN controller.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of the others, independent of block order.
    if (!rst_n) state_q <= RUN;
    else        state_q <= state_d;
  end

  // Next-state logic: enter DRAIN when a redirect leaves stale words in flight,
  // leave it the cycle after the discard count has reached zero.
  always_comb begin
    // NOTE: every combinationally assigned signal gets a default first, so no
    // path through the block can leave it unassigned and infer a latch.
    state_d = state_q;
    unique case (state_q)
      RUN: begin
        if (redirect_valid && (out_nxt != '0)) state_d = DRAIN;
      end
      DRAIN: begin
        if (!redirect_valid && (discard_q == '0)) state_d = RUN;
      end
      default: state_d = RUN;
    endcase
  end

  // Output logic: request while running, credit remains and no redirect.
  always_comb begin
    imem_req_valid = 1'b0;
    if (rst_n && (state_q == RUN) && credit_ok && !redirect_valid)
      imem_req_valid = 1'b1;
  end

  assign imem_req_addr = pc_q;

  // Fetch PC, response PC and the outstanding/discard bookkeeping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q      <= RESET_PC;
      rsp_pc_q  <= RESET_PC;
      out_q     <= '0;
      discard_q <= '0;
    end else begin
      out_q <= out_nxt;
      if (redirect_valid) begin
        pc_q      <= redirect_target;
        rsp_pc_q  <= redirect_target;
        // Everything still outstanding after this cycle belongs to the old
        // path; a response arriving right now is dropped without counting.
        discard_q <= out_nxt;
      end else begin
        if (req_fire) pc_q <= pc_q + N'(4);
        if (push)     rsp_pc_q <= rsp_pc_q + N'(4);
        if (imem_rsp_valid && (discard_q != '0)) discard_q <= discard_q - CW'(1);
      end
    end
  end

  // FIFO pointers and occupancy; a redirect empties the FIFO on the next edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (redirect_valid) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      count_q <= count_q + CW'(push) - CW'(pop);
    end
  end

  // FIFO storage: instruction word and its address.
  always_ff @(posedge clk) begin
    // NOTE: the storage array has no reset; occupancy is reset instead and
    // the outputs are gated by it, so stale contents are never visible.
    if (push) begin
      mem_data[wr_ptr_q] <= imem_rsp_data;
      mem_pc[wr_ptr_q]   <= rsp_pc_q;
    end
  end

  // Decode-side outputs come straight from registered FIFO state.
  always_comb begin
    opcode_valid = (count_q != '0);
    opcode       = '0;
    opcode_pc    = '0;
    if (opcode_valid) begin
      opcode    = mem_data[rd_ptr_q];
      opcode_pc = mem_pc[rd_ptr_q];
    end
  end

`ifdef FETCH_PERF_EN
  // Count cycles where decode is ready but has nothing to take, saturating.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      stall_cycles <= '0;
    else if (opcode_ready && !opcode_valid && (state_q == RUN) && (stall_cycles != '1))
      stall_cycles <= stall_cycles + 32'd1;
  end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: a memory model answering in order with
// random latency, a reference model that tracks which fetched words belong to
// the current control-flow path, and a monitor that checks every opcode handed
// to decode against the expected stream.
module tb_fetch_stage;

  localparam int          N        = 32;
  localparam int          DEPTH    = 2;
  localparam logic [31:0] RESET_PC = 32'h0000_0100;

  typedef struct {
    logic [31:0] addr;
    int          epoch;
    int          due;
  } flight_t;

  typedef struct {
    logic [31:0] data;
    logic [31:0] pc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data  = '0;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [31:0] opcode;
  logic [31:0] opcode_pc;
  logic        opcode_valid;
  logic        opcode_ready;
`ifdef FETCH_PERF_EN
  logic [31:0] stall_cycles;
`endif

  always #5 clk = ~clk;

  fetch_stage #(.N(N), .DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .opcode         (opcode),
    .opcode_pc      (opcode_pc),
    .opcode_valid   (opcode_valid),
    .opcode_ready   (opcode_ready)
`ifdef FETCH_PERF_EN
    ,
    .stall_cycles   (stall_cycles)
`endif
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Instruction memory contents: a fixed scramble of the address.
  function automatic logic [31:0] word_of(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'hC0DE_1234 ^ (a << 3);
  endfunction

  // Memory and reference-model state.
  flight_t     flight[$];   // accepted requests awaiting a response
  exp_t        exp_q[$];    // words decode is expected to receive, in order
  logic [31:0] acc_log[$];  // accepted request addresses, for directed checks
  flight_t     rsp_entry;
  logic [31:0] model_pc = RESET_PC;
  int          epoch    = 0;
  int          cyc      = 0;
  bit          pop_flag = 1'b0;
  int          lat_min  = 1;
  int          lat_max  = 1;
  int          rsp_pct  = 100;

  function automatic logic [31:0] acc_at(input int k);
    return (acc_log.size() > k) ? acc_log[k] : 32'hDEAD_BEEF;
  endfunction

  // Reference model and memory: at each edge account for the cycle just ended,
  // then drive the memory response for the next cycle.
  always @(posedge clk) begin
    cyc++;
    if (!rst_n) begin
      flight.delete();
      exp_q.delete();
      model_pc = RESET_PC;
      epoch++;
      pop_flag = 1'b0;
    end else begin
      if (imem_req_valid && imem_req_ready) begin
        check("req_credit",
              32'(flight.size() + int'(imem_rsp_valid) + exp_q.size() + int'(pop_flag) < DEPTH),
              32'd1);
        check("req_addr", imem_req_addr, model_pc);
        check("req_during_redirect", 32'(redirect_valid), 32'd0);
        acc_log.push_back(imem_req_addr);
        flight.push_back('{addr: model_pc, epoch: epoch,
                           due: cyc + int'($urandom_range(lat_min, lat_max)) - 1});
        model_pc = model_pc + 32'd4;
      end
      if (imem_rsp_valid && (rsp_entry.epoch == epoch) && !redirect_valid)
        exp_q.push_back('{data: word_of(rsp_entry.addr), pc: rsp_entry.addr});
      if (redirect_valid) begin
        epoch++;
        exp_q.delete();
        model_pc = {redirect_pc[31:2], 2'b00};
      end
      pop_flag = 1'b0;
    end
    #1;
    if (rst_n && (flight.size() > 0) && (flight[0].due <= cyc) &&
        ($urandom_range(0, 99) < rsp_pct)) begin
      rsp_entry      = flight.pop_front();
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = word_of(rsp_entry.addr);
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = $urandom;
    end
  end

  // Monitor: every opcode consumed by decode must match the expected stream.
  always @(negedge clk) begin
    if (rst_n && opcode_valid && opcode_ready) begin
      pop_flag = 1'b1;
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL opcode_unexpected: got opcode at pc %h, expected none", opcode_pc);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("opcode", opcode, e.data);
        check("opcode_pc", opcode_pc, e.pc);
      end
    end
  end

  task automatic drive_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_opcode(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      @(negedge clk);
      ok = opcode_valid;
    end
  endtask

  task automatic wait_in_flight(input int want, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(negedge clk);
      ok = (flight.size() == want);
    end
  endtask

  initial begin
    bit          ok;
    int          first_acc;
    int          first_val;
    logic [31:0] held;

    rst_n          = 1'b0;
    imem_req_ready = 1'b0;
    opcode_ready   = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;

    // Reset values.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_req_valid", 32'(imem_req_valid), 32'd0);
    check("rst_opcode_valid", 32'(opcode_valid), 32'd0);
    check("rst_opcode", opcode, 32'd0);
    check("rst_opcode_pc", opcode_pc, 32'd0);
    check("rst_req_addr", imem_req_addr, RESET_PC);
`ifdef FETCH_PERF_EN
    check("rst_stall_cycles", stall_cycles, 32'd0);
`endif

    // Streaming fetch from RESET_PC with a 1-cycle memory.
    drive_edge();
    rst_n          = 1'b1;
    imem_req_ready = 1'b1;
    opcode_ready   = 1'b1;
    first_acc      = -1;
    first_val      = -1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (first_acc < 0 && imem_req_valid && imem_req_ready) begin
        first_acc = i;
        check("first_req_addr", imem_req_addr, RESET_PC);
      end
      if (first_val < 0 && opcode_valid) begin
        first_val = i;
        check("first_opcode_pc", opcode_pc, RESET_PC);
      end
    end
    check("first_latency", 32'(first_val - first_acc), 32'd2);

    // Decode stall: the FIFO fills to DEPTH and issue stops.
    drive_edge();
    opcode_ready = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    check("dstall_req_valid", 32'(imem_req_valid), 32'd0);
    check("dstall_opcode_valid", 32'(opcode_valid), 32'd1);
    check("dstall_fill", 32'(flight.size() + exp_q.size()), 32'(DEPTH));
    drive_edge();
    opcode_ready = 1'b1;
    repeat (10) @(posedge clk);

    // Redirect with two requests in flight.
    #1;
    lat_min = 3;
    lat_max = 3;
    wait_in_flight(2, ok);
    check("two_in_flight", 32'(ok), 32'd1);
    drive_edge();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0203;
    acc_log.delete();
    drive_edge();
    redirect_valid = 1'b0;
    @(negedge clk);
    check("flush_opcode_valid", 32'(opcode_valid), 32'd0);
    wait_opcode(30, ok);
    check("redir_opcode_seen", 32'(ok), 32'd1);
    check("redir_opcode_pc", opcode_pc, 32'h0000_0200);
    check("redir_first_req", acc_at(0), 32'h0000_0200);

    // Second redirect while still draining the first.
    wait_in_flight(2, ok);
    check("two_in_flight_b", 32'(ok), 32'd1);
    drive_edge();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0300;
    acc_log.delete();
    drive_edge();
    redirect_pc    = 32'h0000_0405;
    drive_edge();
    redirect_valid = 1'b0;
    wait_opcode(30, ok);
    check("drain_redir_seen", 32'(ok), 32'd1);
    check("drain_redir_opcode_pc", opcode_pc, 32'h0000_0404);
    check("drain_redir_first_req", acc_at(0), 32'h0000_0404);

    // Memory stall: address holds, then advances by 4.
    drive_edge();
    lat_min        = 1;
    lat_max        = 1;
    imem_req_ready = 1'b0;
    @(negedge clk);
    held = imem_req_addr;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("mstall_addr", imem_req_addr, held);
    end
    check("mstall_req_valid", 32'(imem_req_valid), 32'd1);
    drive_edge();
    imem_req_ready = 1'b1;
    acc_log.delete();
    repeat (4) @(posedge clk);
    check("mstall_resume_0", acc_at(0), held);
    check("mstall_resume_1", acc_at(1), held + 32'd4);

    // PC wrap at the top of the address space.
    drive_edge();
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFFE;
    acc_log.delete();
    drive_edge();
    redirect_valid = 1'b0;
    repeat (10) @(posedge clk);
    check("wrap_req_0", acc_at(0), 32'hFFFF_FFFC);
    check("wrap_req_1", acc_at(1), 32'h0000_0000);

    // Randomized traffic.
    #1;
    lat_min = 1;
    lat_max = 4;
    rsp_pct = 75;
    for (int i = 0; i < 1500; i++) begin
      drive_edge();
      imem_req_ready = ($urandom_range(0, 99) < 70);
      opcode_ready   = ($urandom_range(0, 99) < 65);
      redirect_valid = ($urandom_range(0, 99) < 3);
      redirect_pc    = $urandom;
    end
    drive_edge();
    redirect_valid = 1'b0;
    lat_min        = 1;
    lat_max        = 1;
    rsp_pct        = 100;

    // Asynchronous reset with the FIFO full.
    imem_req_ready = 1'b1;
    opcode_ready   = 1'b0;
    repeat (8) @(posedge clk);
    @(negedge clk);
    check("full_before_reset", 32'(opcode_valid), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_opcode_valid", 32'(opcode_valid), 32'd0);
    check("async_rst_req_valid", 32'(imem_req_valid), 32'd0);
    check("async_rst_opcode_pc", opcode_pc, 32'd0);
    drive_edge();
    imem_req_ready = 1'b0;
    drive_edge();
    rst_n = 1'b1;
`ifdef FETCH_PERF_EN
    @(negedge clk);
    check("perf_after_reset", stall_cycles, 32'd0);
    drive_edge();
    opcode_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    opcode_ready = 1'b0;
    @(negedge clk);
    check("perf_stall_cycles", stall_cycles, 32'd3);
`endif
    drive_edge();
    acc_log.delete();
    imem_req_ready = 1'b1;
    opcode_ready   = 1'b1;
    repeat (6) @(posedge clk);
    check("restart_req_addr", acc_at(0), RESET_PC);

    // Drain: stop issuing and let every expected word reach decode.
    drive_edge();
    imem_req_ready = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 60 && !ok; i++) begin
      @(negedge clk);
      ok = (flight.size() == 0) && (exp_q.size() == 0) && !opcode_valid && !imem_rsp_valid;
    end
    check("drain_complete", 32'(ok), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
